// File: rtl/fpmul_pipe.sv
// fpmul_pipe: 3-stage pipelined floating-point multiplier with valid/ready handshake and sideband tag
// Build option: define FPMUL_RNE_EN for round-to-nearest-even, otherwise truncate toward zero.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, opr_a/opr_b {sign,exp,frac}, in_tag;
//        out_valid/out_ready, result {sign,exp,frac}, out_tag, out_flags {nan,inf,overflow,underflow}.
module fpmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opr_a,
    input  logic [EXP_W+MAN_W:0]   opr_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int P = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
`ifdef FPMUL_RNE_EN
    localparam int KW = P;
`else
    localparam int KW = MAN_W + 2;
`endif
    localparam logic [1:0] SP_NORM = 2'd0, SP_ZERO = 2'd1, SP_INF = 2'd2, SP_NAN = 2'd3;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    assign advance = ~out_valid | out_ready;
    assign in_ready = advance;

    logic sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb;
    logic [1:0] sp_in;
    logic signed [XW-1:0] exp_in;
    assign {sa, ea, fa} = opr_a;
    assign {sb, eb, fb} = opr_b;
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = ea == EMAX && fa == '0;
    assign ib = eb == EMAX && fb == '0;
    assign na = ea == EMAX && fa != '0;
    assign nb = eb == EMAX && fb != '0;
    assign sp_in = (na | nb | (ia & zb) | (za & ib)) ? SP_NAN : (ia | ib) ? SP_INF : (za | zb) ? SP_ZERO : SP_NORM;
    assign exp_in = {2'b00, ea} + {2'b00, eb} - XW'(BIAS);

    logic v1, v2, sg1, sg2;
    logic [TAG_W-1:0] tag1, tag2;
    logic signed [XW-1:0] ex1, ex2;
    logic [MAN_W:0] ma1, mb1;
    logic [1:0] sp1, sp2;
    logic [P-1:0] mul;
    logic [KW-1:0] prod2;
    assign mul = {{(MAN_W+1){1'b0}}, ma1} * {{(MAN_W+1){1'b0}}, mb1};

    // Product lies in [1,4): the top bit selects a one-place renormalisation.
    logic hi, ovf, unf;
    logic [MAN_W-1:0] fr_t, fr_f;
    logic signed [XW-1:0] ex_n, ex_f;
    logic [W-1:0] res_n;
    logic [3:0] fl_n;
    assign hi = prod2[KW-1];
    assign fr_t = hi ? prod2[KW-2 -: MAN_W] : prod2[KW-3 -: MAN_W];
    assign ex_n = ex2 + XW'(hi);
`ifdef FPMUL_RNE_EN
    logic g, st, rnd;
    logic [MAN_W:0] fr_r;
    assign g = hi ? prod2[KW-2-MAN_W] : prod2[KW-3-MAN_W];
    assign st = hi ? |prod2[KW-3-MAN_W:0] : |prod2[KW-4-MAN_W:0];
    assign rnd = g & (st | fr_t[0]);
    assign fr_r = {1'b0, fr_t} + (MAN_W+1)'(rnd);
    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign ex_f = ex_n + XW'(fr_r[MAN_W]);
    assign fr_f = fr_r[MAN_W-1:0];
`else
    assign ex_f = ex_n;
    assign fr_f = fr_t;
`endif
    assign ovf = ex_f >= (2 ** EXP_W - 1);
    assign unf = ex_f <= 0;
    assign res_n = sp2 == SP_NAN ? QNAN :
                   (sp2 == SP_INF || (sp2 == SP_NORM && ovf)) ? {sg2, EMAX, {MAN_W{1'b0}}} :
                   (sp2 == SP_ZERO || unf) ? {sg2, {(W-1){1'b0}}} : {sg2, ex_f[EXP_W-1:0], fr_f};
    assign fl_n = {sp2 == SP_NAN, sp2 == SP_INF, sp2 == SP_NORM && ovf, sp2 == SP_NORM && !ovf && unf};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            result <= '0;
            out_tag <= '0;
            out_flags <= '0;
        end else if (advance) begin
            v1 <= in_valid;
            tag1 <= in_tag;
            sg1 <= sa ^ sb;
            ex1 <= exp_in;
            ma1 <= {1'b1, fa};
            mb1 <= {1'b1, fb};
            sp1 <= sp_in;
            v2 <= v1;
            tag2 <= tag1;
            sg2 <= sg1;
            ex2 <= ex1;
            sp2 <= sp1;
            prod2 <= KW'(mul >> (P - KW));
            out_valid <= v2;
            result <= res_n;
            out_tag <= tag2;
            out_flags <= fl_n;
        end
    end
endmodule
